// File: rtl/display_scanner.sv
// Four-digit multiplexed 7-segment scanner for the dozens/tray cork counters.
// Shadow-latches the BCD inputs once per frame, with leading-zero blanking and tray-digit blinking.
module display_scanner #(
    parameter int SCAN_DIV     = 6,
    parameter int BLINK_FRAMES = 125
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic [3:0] dezenas_duzias,
    input  logic [3:0] unidades_duzias,
    input  logic [3:0] dezenas_bandeja,
    input  logic [3:0] unidades_bandeja,
    input  logic       blink_bandeja,
    output logic [3:0] display_colune,
    output logic [6:0] display_data,
    output logic       frame_start
);

    localparam logic [7:0] PRESC_LAST = 8'(SCAN_DIV - 1);
    localparam logic [9:0] BLINK_LAST = 10'(BLINK_FRAMES - 1);
    localparam logic [6:0] SEG_OFF    = 7'b1111111;

    logic [7:0]      presc, presc_next;
    logic [1:0]      idx, idx_next;
    logic [3:0][3:0] shadow, shadow_next;
    logic [9:0]      bcnt, bcnt_next;
    logic            phase, phase_next;
    logic            frame_wrap;
    logic [3:0]      digit;
    logic [3:0]      colune_next;
    logic [6:0]      data_next;

    // Active-low segments, bit6..bit0 = a..g; non-BCD codes show a dash.
    function automatic logic [6:0] seg_decode(input logic [3:0] v);
        case (v)
            4'd0:    seg_decode = 7'b0000001;
            4'd1:    seg_decode = 7'b1001111;
            4'd2:    seg_decode = 7'b0010010;
            4'd3:    seg_decode = 7'b0000110;
            4'd4:    seg_decode = 7'b1001100;
            4'd5:    seg_decode = 7'b0100100;
            4'd6:    seg_decode = 7'b0100000;
            4'd7:    seg_decode = 7'b0001111;
            4'd8:    seg_decode = 7'b0000000;
            4'd9:    seg_decode = 7'b0000100;
            default: seg_decode = 7'b1111110;
        endcase
    endfunction

    always_comb begin
        presc_next  = presc + 8'd1;
        idx_next    = idx;
        frame_wrap  = 1'b0;
        shadow_next = shadow;
        bcnt_next   = bcnt;
        phase_next  = phase;
        if (presc == PRESC_LAST) begin
            presc_next = 8'd0;
            idx_next   = idx + 2'd1;
            frame_wrap = (idx == 2'd3);
        end
        if (frame_wrap)
            shadow_next = {unidades_bandeja, dezenas_bandeja, unidades_duzias, dezenas_duzias};

        if (!blink_bandeja) begin
            bcnt_next  = 10'd0;
            phase_next = 1'b0;
        end else if (frame_wrap) begin
            if (bcnt == BLINK_LAST) begin
                bcnt_next  = 10'd0;
                phase_next = ~phase;
            end else begin
                bcnt_next = bcnt + 10'd1;
            end
        end

        // Outputs are computed from the next index and shadow so column and segments switch together.
        colune_next = ~(4'b1000 >> idx_next);
        digit       = shadow_next[idx_next];
        if (!enable)
            data_next = SEG_OFF;
        else if (blink_bandeja && phase_next && idx_next[1])
            data_next = SEG_OFF;
        else if (!idx_next[0] && digit == 4'd0)
            data_next = SEG_OFF;
        else
            data_next = seg_decode(digit);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            presc          <= 8'd0;
            idx            <= 2'd0;
            shadow         <= '0;
            bcnt           <= 10'd0;
            phase          <= 1'b0;
            display_colune <= 4'b0111;
            display_data   <= SEG_OFF;
            frame_start    <= 1'b0;
        end else begin
            presc          <= presc_next;
            idx            <= idx_next;
            shadow         <= shadow_next;
            bcnt           <= bcnt_next;
            phase          <= phase_next;
            display_colune <= colune_next;
            display_data   <= data_next;
            frame_start    <= frame_wrap;
        end
    end

endmodule

// File: tb/tb_display_scanner.sv
// Bench for display_scanner: vector table, hand-written corner sequences and a
// randomized run, all checked each cycle against a frame-level reference model.
module tb_display_scanner;

    localparam int SD = 6;
    localparam int BF = 2;
    localparam int FRAME = 4 * SD;
    localparam logic [6:0] OFF  = 7'b1111111;
    localparam logic [6:0] DASH = 7'b1111110;
    localparam logic [6:0] GLYPH [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                                          7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                                          7'b0000000, 7'b0000100};

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic [3:0] d0 = 4'd0, d1 = 4'd0, d2 = 4'd0, d3 = 4'd0;
    logic       blink = 1'b0;
    logic [3:0] display_colune;
    logic [6:0] display_data;
    logic       frame_start;

    display_scanner #(.SCAN_DIV(SD), .BLINK_FRAMES(BF)) dut (
        .clk(clk), .reset(reset), .enable(enable),
        .dezenas_duzias(d0), .unidades_duzias(d1),
        .dezenas_bandeja(d2), .unidades_bandeja(d3),
        .blink_bandeja(blink),
        .display_colune(display_colune), .display_data(display_data),
        .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    // Reference model: k = rising edges since reset release; everything derives from it.
    int         k = 0;
    int         wraps_blink = 0;
    logic [3:0] sh [4];
    logic [3:0] exp_col;
    logic [6:0] exp_data;
    logic       exp_fs;

    task automatic check(input string name, input int got, input int want);
        total++;
        if (got == want) passed++;
        else $display("FAIL %s @%0t: got %0h expected %0h", name, $time, got, want);
    endtask

    function automatic logic [6:0] glyph(input logic [3:0] v);
        if (v > 4'd9) return DASH;
        return GLYPH[v];
    endfunction

    task automatic model_edge();
        int d;
        bit wrap;
        if (!reset) begin
            k = 0; wraps_blink = 0;
            for (int i = 0; i < 4; i++) sh[i] = 4'd0;
            exp_col = 4'b0111; exp_data = OFF; exp_fs = 1'b0;
        end else begin
            k++;
            wrap = (k % FRAME) == 0;
            if (wrap) begin
                sh[0] = d0; sh[1] = d1; sh[2] = d2; sh[3] = d3;
            end
            if (!blink) wraps_blink = 0;
            else if (wrap) wraps_blink++;
            d = (k / SD) % 4;
            exp_col = 4'b1111;
            exp_col[3 - d] = 1'b0;
            exp_fs = wrap;
            if (!enable) exp_data = OFF;
            else if (blink && ((wraps_blink / BF) % 2 == 1) && d >= 2) exp_data = OFF;
            else if ((d == 0 || d == 2) && sh[d] == 4'd0) exp_data = OFF;
            else exp_data = glyph(sh[d]);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check("col", display_colune, exp_col);
        check("data", display_data, exp_data);
        check("frame_start", frame_start, exp_fs);
    endtask

    task automatic run_to(input int p);
        int n = 0;
        do begin
            tick();
            n++;
        end while ((k % FRAME) != p && n < 2 * FRAME);
        check("run_to_bound", (k % FRAME), p);
    endtask

    typedef struct {
        logic       en;
        logic [3:0] i0, i1, i2, i3;
        logic [6:0] e0, e1, e2, e3;
    } vec_t;
    vec_t vecs [6];
    logic [6:0] got [4];

    initial begin
        vecs[0] = '{1'b1, 4'd0, 4'd7, 4'd1, 4'd2, OFF, 7'b0001111, 7'b1001111, 7'b0010010};
        vecs[1] = '{1'b1, 4'd0, 4'd0, 4'd0, 4'd0, OFF, 7'b0000001, OFF, 7'b0000001};
        vecs[2] = '{1'b1, 4'd0, 4'd12, 4'd0, 4'd5, OFF, DASH, OFF, 7'b0100100};
        vecs[3] = '{1'b0, 4'd8, 4'd8, 4'd8, 4'd8, OFF, OFF, OFF, OFF};
        vecs[4] = '{1'b1, 4'd8, 4'd9, 4'd3, 4'd4, 7'b0000000, 7'b0000100, 7'b0000110, 7'b1001100};
        vecs[5] = '{1'b1, 4'd15, 4'd10, 4'd1, 4'd0, DASH, DASH, 7'b1001111, 7'b0000001};

        // Reset state, asserted before any clock edge.
        #2 reset = 1'b0;
        #1;
        check("reset_col", display_colune, 4'b0111);
        check("reset_data", display_data, OFF);
        check("reset_fs", frame_start, 1'b0);
        repeat (3) tick();
        reset = 1'b1;
        enable = 1'b1;

        // Digit 0 dwells a full SCAN_DIV after release, then frame_start every 24 cycles.
        for (int i = 0; i < SD; i++) begin
            tick();
            check("dwell0", display_colune, (i < SD - 1) ? 4'b0111 : 4'b1011);
        end
        begin
            int n = 0;
            while (frame_start !== 1'b1 && n < 60) begin tick(); n++; end
            check("fs_seen", frame_start, 1'b1);
            n = 0;
            do begin tick(); n++; end while (frame_start !== 1'b1 && n < 60);
            check("fs_period", n, FRAME);
        end

        // Table-driven decode / blanking / enable vectors.
        foreach (vecs[v]) begin
            enable = vecs[v].en;
            d0 = vecs[v].i0; d1 = vecs[v].i1; d2 = vecs[v].i2; d3 = vecs[v].i3;
            run_to(0);  got[0] = display_data;
            run_to(SD); got[1] = display_data;
            run_to(2*SD); got[2] = display_data;
            run_to(3*SD); got[3] = display_data;
            check($sformatf("vec%0d_dig0", v), got[0], vecs[v].e0);
            check($sformatf("vec%0d_dig1", v), got[1], vecs[v].e1);
            check($sformatf("vec%0d_dig2", v), got[2], vecs[v].e2);
            check($sformatf("vec%0d_dig3", v), got[3], vecs[v].e3);
        end

        // Anti-tearing: change digit 3 while index 1 is lit.
        enable = 1'b1; d0 = 4'd1; d1 = 4'd1; d2 = 4'd1; d3 = 4'd3;
        run_to(0);
        run_to(SD);
        d3 = 4'd9;
        run_to(3*SD);
        check("tear_same_frame", display_data, 7'b0000110);
        run_to(3*SD);
        check("tear_next_frame", display_data, 7'b0000100);

        // Blink: two frames visible, two blank; digits 0-1 unaffected.
        d0 = 4'd1; d1 = 4'd2; d2 = 4'd3; d3 = 4'd4;
        run_to(0);
        blink = 1'b1;
        for (int f = 0; f < 8; f++) begin
            run_to(SD);
            check($sformatf("blink_f%0d_dig1", f), display_data, 7'b0010010);
            run_to(2*SD);
            check($sformatf("blink_f%0d_dig2", f), display_data, ((f / 2) % 2) ? OFF : 7'b0000110);
            run_to(3*SD);
            check($sformatf("blink_f%0d_dig3", f), display_data, ((f / 2) % 2) ? OFF : 7'b1001100);
        end
        blink = 1'b0;
        tick();
        check("blink_drop", display_data, 7'b1001100);

        // Async reset mid-cycle during index 2.
        run_to(2*SD);
        tick(); tick();
        #3 reset = 1'b0;
        #1;
        check("areset_col", display_colune, 4'b0111);
        check("areset_data", display_data, OFF);
        check("areset_fs", frame_start, 1'b0);
        repeat (2) tick();
        reset = 1'b1;
        for (int i = 0; i < SD; i++) begin
            tick();
            check("restart_dwell", display_colune, (i < SD - 1) ? 4'b0111 : 4'b1011);
        end

        // Randomized run against the model.
        for (int i = 0; i < 1500; i++) begin
            tick();
            if ($urandom_range(0, 9) == 0) d0 = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 9) == 0) d1 = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 9) == 0) d2 = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 9) == 0) d3 = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 49) == 0) enable = ~enable;
            if ($urandom_range(0, 99) == 0) blink = ~blink;
            if ($urandom_range(0, 399) == 0) begin
                reset = 1'b0;
                tick();
                reset = 1'b1;
            end
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
